block_draw_scheduler: RTL and testbench

BLOCK_DRAW_SCHEDULER -- requirements
Module: block_draw_scheduler

---
 rtl/block_draw_scheduler.sv | 178 +++++++++++++++++
 tb/tb_block_draw_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_draw_scheduler.sv
// Block-draw scheduler: round-robin arbitration of requesters onto one VGA pixel port.
// Latency: grant one cycle after req in IDLE, first pixel one cycle later, done after size*size+1.
// Backpressure: requests are level-held; a pending request waits until the FSM returns to IDLE.
module block_draw_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  input  logic [4*NUM_REQ-1:0]   req_size,
  output logic [7:0]             plot_x,
  output logic [6:0]             plot_y,
  output logic [2:0]             plot_colour,
  output logic                   plot,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t               state, nxt_state;
  logic [IW-1:0]        last_grant, nxt_last_grant;
  logic [IW-1:0]        win, nxt_win;
  logic [7:0]           lat_x, nxt_lat_x;
  logic [6:0]           lat_y, nxt_lat_y;
  logic [2:0]           lat_c, nxt_lat_c;
  logic [3:0]           lat_s, nxt_lat_s;
  logic [3:0]           off_x, nxt_off_x;
  logic [3:0]           off_y, nxt_off_y;
  logic [7:0]           nxt_plot_x;
  logic [6:0]           nxt_plot_y;
  logic [2:0]           nxt_plot_colour;
  logic                 nxt_plot;
  logic [NUM_REQ-1:0]   nxt_grant, nxt_done;
  logic                 nxt_busy;

  // Round-robin candidate: first asserted req starting just above the last owner
  logic                 found;
  logic [IW-1:0]        sel;
  logic [7:0]           cand_x;
  logic [6:0]           cand_y;
  logic [2:0]           cand_c;
  logic [3:0]           cand_s;
  int                   idx;

  // Nine/eight-bit sums so that off-screen pixels are detected rather than wrapped
  logic [8:0]           sum_x;
  logic [7:0]           sum_y;

  // Search requesters in rotating priority order and pick up the winner's block parameters
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    cand_x = '0;
    cand_y = '0;
    cand_c = '0;
    cand_s = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel    = IW'(idx);
        cand_x = req_x[idx*8 +: 8];
        cand_y = req_y[idx*7 +: 7];
        cand_c = req_colour[idx*3 +: 3];
        cand_s = req_size[idx*4 +: 4];
      end
    end
  end

  assign sum_x = {1'b0, lat_x} + {5'b0, off_x};
  assign sum_y = {1'b0, lat_y} + {4'b0, off_y};

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    nxt_state       = state;
    nxt_last_grant  = last_grant;
    nxt_win         = win;
    nxt_lat_x       = lat_x;
    nxt_lat_y       = lat_y;
    nxt_lat_c       = lat_c;
    nxt_lat_s       = lat_s;
    nxt_off_x       = off_x;
    nxt_off_y       = off_y;
    nxt_plot_x      = plot_x;
    nxt_plot_y      = plot_y;
    nxt_plot_colour = plot_colour;
    nxt_plot        = 1'b0;
    nxt_grant       = grant;
    nxt_done        = '0;
    case (state)
      IDLE: begin
        nxt_grant = '0;
        if (found) begin
          nxt_grant[sel] = 1'b1;
          nxt_win        = sel;
          nxt_lat_x      = cand_x;
          nxt_lat_y      = cand_y;
          nxt_lat_c      = cand_c;
          nxt_lat_s      = cand_s;
          nxt_off_x      = '0;
          nxt_off_y      = '0;
          // A zero-sized block has nothing to draw and completes straight away
          nxt_state      = (cand_s == 4'd0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        nxt_plot_x      = sum_x[7:0];
        nxt_plot_y      = sum_y[6:0];
        nxt_plot_colour = lat_c;
        nxt_plot        = (sum_x <= 9'd159) && (sum_y <= 8'd119);
        if (off_x == lat_s - 4'd1) begin
          nxt_off_x = '0;
          if (off_y == lat_s - 4'd1) nxt_state = DONE;
          else nxt_off_y = off_y + 4'd1;
        end else begin
          nxt_off_x = off_x + 4'd1;
        end
      end
      DONE: begin
        nxt_done       = grant;
        nxt_grant      = '0;
        nxt_last_grant = win;
        nxt_state      = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    nxt_busy = (nxt_state != IDLE);
  end

  // State and output registers; reset parks the arbiter so index 0 wins first
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_REQ - 1);
      win         <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      lat_c       <= '0;
      lat_s       <= '0;
      off_x       <= '0;
      off_y       <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot        <= 1'b0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      last_grant  <= nxt_last_grant;
      win         <= nxt_win;
      lat_x       <= nxt_lat_x;
      lat_y       <= nxt_lat_y;
      lat_c       <= nxt_lat_c;
      lat_s       <= nxt_lat_s;
      off_x       <= nxt_off_x;
      off_y       <= nxt_off_y;
      plot_x      <= nxt_plot_x;
      plot_y      <= nxt_plot_y;
      plot_colour <= nxt_plot_colour;
      plot        <= nxt_plot;
      grant       <= nxt_grant;
      done        <= nxt_done;
      busy        <= nxt_busy;
    end
  end

endmodule

// File: tb/tb_block_draw_scheduler.sv
// Bench for block_draw_scheduler: table of single-requester blocks plus hand sequences.
// Latency checked cycle by cycle against hand-derived raster order and clipping.
// Requests are held by the bench until the done pulse unless a sequence says otherwise.
module tb_block_draw_scheduler;

  localparam int N = 4;

  logic           clock;
  logic           resetn;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic [4*N-1:0] req_size;
  logic [7:0]     plot_x;
  logic [6:0]     plot_y;
  logic [2:0]     plot_colour;
  logic           plot;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  block_draw_scheduler #(.NUM_REQ(N)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .req_size(req_size), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot), .grant(grant), .done(done), .busy(busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [3:0] s;
    int         exp_plots;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input logic [3:0] s);
    req_x[i*8 +: 8]      = x;
    req_y[i*7 +: 7]      = y;
    req_colour[i*3 +: 3] = c;
    req_size[i*4 +: 4]   = s;
  endtask

  task automatic chk_reset_state();
    chk("rst_plot", 32'(plot), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot_x", 32'(plot_x), 0);
    chk("rst_plot_y", 32'(plot_y), 0);
    chk("rst_colour", 32'(plot_colour), 0);
  endtask

  // Wait (bounded) for a done pulse, counting visible pixels on the way
  task automatic wait_done(input logic [N-1:0] exp_mask, input int budget, output int plots);
    int w;
    plots = 0;
    w = 0;
    while (done == '0 && w < budget) begin
      step();
      if (plot) plots++;
      w++;
    end
    chk("done_seen", 32'(done), 32'(exp_mask));
  endtask

  // One block from one requester: grant, raster pixels, clipping, done pulse
  task automatic run_block(input vec_t v);
    int ex, ey, plots;
    set_slot(v.idx, v.x, v.y, v.c, v.s);
    req = '0;
    req[v.idx] = 1'b1;
    step();
    chk("grant", 32'(grant), 32'(1) << v.idx);
    chk("busy", 32'(busy), 1);
    chk("no_plot_at_grant", 32'(plot), 0);
    plots = 0;
    for (int t = 0; t < int'(v.s) * int'(v.s); t++) begin
      step();
      ex = int'(v.x) + (t % int'(v.s));
      ey = int'(v.y) + (t / int'(v.s));
      chk("px_x", 32'(plot_x), 32'(ex & 255));
      chk("px_y", 32'(plot_y), 32'(ey & 127));
      chk("px_plot", 32'(plot), 32'((ex <= 159) && (ey <= 119)));
      chk("px_colour", 32'(plot_colour), 32'(v.c));
      chk("px_grant", 32'(grant), 32'(1) << v.idx);
      if (plot) plots++;
    end
    step();
    chk("done", 32'(done), 32'(1) << v.idx);
    chk("grant_clear", 32'(grant), 0);
    chk("plot_count", 32'(plots), 32'(v.exp_plots));
    req = '0;
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int plots;
    int w;
    tbl[0] = '{idx: 0, x: 8'd10,  y: 7'd20,  c: 3'd4, s: 4'd3,  exp_plots: 9};
    tbl[1] = '{idx: 1, x: 8'd158, y: 7'd118, c: 3'd2, s: 4'd4,  exp_plots: 4};
    tbl[2] = '{idx: 2, x: 8'd5,   y: 7'd5,   c: 3'd1, s: 4'd0,  exp_plots: 0};
    tbl[3] = '{idx: 3, x: 8'd0,   y: 7'd0,   c: 3'd7, s: 4'd1,  exp_plots: 1};
    tbl[4] = '{idx: 0, x: 8'd150, y: 7'd100, c: 3'd5, s: 4'd15, exp_plots: 150};
    tbl[5] = '{idx: 2, x: 8'd255, y: 7'd127, c: 3'd3, s: 4'd2,  exp_plots: 0};

    resetn = 1'b0;
    req = '0;
    req_x = '0;
    req_y = '0;
    req_colour = '0;
    req_size = '0;
    #25;
    chk_reset_state();
    @(negedge clock);
    resetn = 1'b1;
    step();
    chk("idle_no_req_plot", 32'(plot), 0);
    chk("idle_no_req_grant", 32'(grant), 0);
    chk("idle_no_req_busy", 32'(busy), 0);

    for (int i = 0; i < 6; i++) run_block(tbl[i]);

    // Four held size-1 requests after reset: grants rotate 0,1,2,3,0
    resetn = 1'b0;
    for (int i = 0; i < N; i++) set_slot(i, 8'(i * 10), 7'(i), 3'(i + 1), 4'd1);
    req = 4'b1111;
    #2;
    chk_reset_state();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (grant == '0 && w < 6) begin
        step();
        w++;
      end
      chk("rr_grant", 32'(grant), 32'(1) << (k % N));
      step();
      chk("rr_plot", 32'(plot), 1);
      chk("rr_plot_x", 32'(plot_x), 32'((k % N) * 10));
      step();
      chk("rr_done", 32'(done), 32'(1) << (k % N));
    end
    req = '0;
    step();
    chk("rr_idle", 32'(busy), 0);

    // Reset after the fifth pixel of a size-4 block aborts it; index 0 wins afterwards
    set_slot(0, 8'd30, 7'd40, 3'd6, 4'd4);
    set_slot(1, 8'd70, 7'd70, 3'd2, 4'd1);
    req = 4'b0001;
    step();
    chk("ab_grant", 32'(grant), 1);
    for (int t = 0; t < 5; t++) step();
    chk("ab_px5_x", 32'(plot_x), 30);
    chk("ab_px5_y", 32'(plot_y), 41);
    req = 4'b0011;
    resetn = 1'b0;
    #1;
    chk_reset_state();
    for (int t = 0; t < 2; t++) begin
      step();
      chk("ab_no_done", 32'(done), 0);
      chk("ab_grant_low", 32'(grant), 0);
    end
    resetn = 1'b1;
    step();
    chk("ab_regrant0", 32'(grant), 1);
    step();
    chk("ab_first_plot", 32'(plot), 1);
    chk("ab_first_x", 32'(plot_x), 30);
    chk("ab_first_y", 32'(plot_y), 40);
    wait_done(4'b0001, 20, plots);
    chk("ab_plot_count", 32'(plots + 1), 16);
    req = '0;
    step();

    // Owner drops req and x changes mid-draw; a request arriving meanwhile waits for IDLE
    set_slot(3, 8'd50, 7'd60, 3'd6, 4'd2);
    req = 4'b1000;
    step();
    chk("own_grant", 32'(grant), 8);
    req = 4'b0010;
    set_slot(3, 8'd99, 7'd10, 3'd1, 4'd5);
    plots = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("own_px_x", 32'(plot_x), 32'(50 + (t % 2)));
      chk("own_px_y", 32'(plot_y), 32'(60 + (t / 2)));
      chk("own_grant_hold", 32'(grant), 8);
      if (plot) plots++;
    end
    chk("own_plot_count", 32'(plots), 4);
    step();
    chk("own_done", 32'(done), 8);
    step();
    chk("pend_grant", 32'(grant), 2);
    req = '0;
    w = 0;
    while (busy && w < 10) begin
      step();
      w++;
    end
    chk("pend_finish", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
